// File: rtl/thread_msg_engine.sv
// Thread-control request engine: turns FORK/STOP commands into dispatcher messages and waits for the reply.
// Optional resend on reply timeout is enabled by defining THREAD_MSG_RETRY_EN.
module thread_msg_engine #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              MSG_W     = 8,
    parameter int              HDR_SPACE = 16,
    parameter int              TIMEOUT   = 255,
    parameter int              MAX_RETRY = 2,
    parameter logic [3:0]      CMD_FORK  = 4'h4,
    parameter logic [3:0]      CMD_STOP  = 4'h5,
    parameter logic [MSG_W-1:0] FORK_THRD = 'h21,
    parameter logic [MSG_W-1:0] FORK_DONE = 'h22,
    parameter logic [MSG_W-1:0] STOP_THRD = 'h31,
    parameter logic [MSG_W-1:0] STOP_DONE = 'h32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [3:0]        i_cmd_code,
    input  logic [DATA_W-1:0] i_src0,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_base_addr_data,
    input  logic              i_disp_online,
    input  logic [MSG_W-1:0]  i_msg_in,
    output logic [MSG_W-1:0]  o_msg_out,
    output logic              o_msg_oe,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_oe,
    output logic              o_busy,
    output logic              o_next_state,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0]       TimerLast = 16'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] HdrOffset = ADDR_W'(HDR_SPACE);

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_timer;
    logic              r_is_stop;
    logic              r_err;
    logic              r_skip;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    logic              w_cmd_ok;
    logic              w_cmd_stop;
    logic              w_timer_hit;
    logic              w_fail;
    logic              w_retry_now;
    logic [ADDR_W-1:0] w_hdr;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_data_a;
    logic [MSG_W-1:0]  w_done_code;

`ifdef THREAD_MSG_RETRY_EN
    localparam logic [7:0] RetryLimit = 8'(MAX_RETRY);
    logic [7:0] r_retry;
`endif

    assign w_cmd_stop  = (i_cmd_code == CMD_STOP);
    assign w_cmd_ok    = (i_cmd_code == CMD_FORK) || w_cmd_stop;
    assign w_timer_hit = (r_timer == TimerLast);
    assign w_done_code = r_is_stop ? STOP_DONE : FORK_DONE;

    // STOP targets sit behind the thread header, so both pointers are pulled back by it.
    assign w_hdr    = w_cmd_stop ? HdrOffset : '0;
    assign w_addr   = ADDR_W'(i_src0) + i_base_addr - w_hdr;
    assign w_data_a = (i_src1 == '0) ? '0
                    : ADDR_W'(i_src1) + i_base_addr_data - w_hdr;

    always_comb begin
        w_state_next = r_state;
        w_fail       = 1'b0;
        w_retry_now  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_cmd_ok) begin
                        w_state_next = i_disp_online ? S_SEND : S_HOLD;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_HOLD: begin
                if (i_disp_online) begin
                    w_state_next = S_SEND;
                end else if (w_timer_hit) begin
                    w_state_next = S_DONE;
                    w_fail       = 1'b1;
                end
            end
            S_SEND: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_msg_in == w_done_code) begin
                    w_state_next = S_DONE;
                end else if (!i_disp_online) begin
                    w_state_next = S_DONE;
                    w_fail       = 1'b1;
                end else if (w_timer_hit) begin
`ifdef THREAD_MSG_RETRY_EN
                    if (r_retry < RetryLimit) begin
                        w_state_next = S_SEND;
                        w_retry_now  = 1'b1;
                    end else begin
                        w_state_next = S_DONE;
                        w_fail       = 1'b1;
                    end
`else
                    w_state_next = S_DONE;
                    w_fail       = 1'b1;
`endif
                end
            end
            S_DONE: begin
                // Unsupported commands linger one extra cycle before completing.
                if (!r_skip) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_is_stop <= 1'b0;
            r_err     <= 1'b0;
            r_skip    <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
`ifdef THREAD_MSG_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_timer <= '0;
                        r_err   <= 1'b0;
                        r_skip  <= !w_cmd_ok;
`ifdef THREAD_MSG_RETRY_EN
                        r_retry <= '0;
`endif
                        if (w_cmd_ok) begin
                            r_is_stop <= w_cmd_stop;
                            r_addr    <= w_addr;
                            r_data    <= DATA_W'(w_data_a);
                        end
                    end
                end
                S_HOLD, S_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                end
                S_SEND: begin
                    r_timer <= '0;
                end
                S_DONE: begin
                    r_skip <= 1'b0;
                end
                default: begin
                end
            endcase
            if (w_fail) begin
                r_err <= 1'b1;
            end
`ifdef THREAD_MSG_RETRY_EN
            if (w_retry_now) begin
                r_retry <= r_retry + 8'd1;
            end
`endif
        end
    end

    // Outputs decode straight from state so an async reset clears them immediately.
    assign o_msg_oe     = (r_state == S_SEND);
    assign o_msg_out    = o_msg_oe ? (r_is_stop ? STOP_THRD : FORK_THRD) : '0;
    assign o_bus_oe     = (r_state == S_SEND) || (r_state == S_WAIT);
    assign o_bus_addr   = r_addr;
    assign o_bus_data   = r_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_next_state = (r_state == S_DONE) && !r_skip;
    assign o_error      = o_next_state && r_err;

endmodule

// File: tb/tb_thread_msg_engine.sv
// Self-checking bench for thread_msg_engine: directed scenarios plus randomized commands
// checked against a cycle-count model derived from the command/reply rules.
`timescale 1ns/1ps
module tb_thread_msg_engine;

    localparam int         TIMEOUT   = 12;
    localparam int         MAX_RETRY = 2;
    localparam int         HDR_SPACE = 16;
    localparam logic [3:0] CMD_FORK  = 4'h4;
    localparam logic [3:0] CMD_STOP  = 4'h5;
    localparam logic [7:0] FORK_THRD = 8'h21;
    localparam logic [7:0] FORK_DONE = 8'h22;
    localparam logic [7:0] STOP_THRD = 8'h31;
    localparam logic [7:0] STOP_DONE = 8'h32;
`ifdef THREAD_MSG_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif

    logic        clk;
    logic        rstN;
    logic        start;
    logic [3:0]  cmdCode;
    logic [31:0] src0, src1, baseAddr, baseAddrData;
    logic        dispOnline;
    logic [7:0]  msgIn;
    logic [7:0]  msgOut;
    logic        msgOe;
    logic [31:0] busAddr, busData;
    logic        busOe, busy, nextState, error;

    int tests = 0;
    int fails = 0;

    thread_msg_engine #(
        .ADDR_W(32), .DATA_W(32), .MSG_W(8), .HDR_SPACE(HDR_SPACE),
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY),
        .CMD_FORK(CMD_FORK), .CMD_STOP(CMD_STOP),
        .FORK_THRD(FORK_THRD), .FORK_DONE(FORK_DONE),
        .STOP_THRD(STOP_THRD), .STOP_DONE(STOP_DONE)
    ) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_cmd_code(cmdCode),
        .i_src0(src0), .i_src1(src1), .i_base_addr(baseAddr),
        .i_base_addr_data(baseAddrData), .i_disp_online(dispOnline),
        .i_msg_in(msgIn), .o_msg_out(msgOut), .o_msg_oe(msgOe),
        .o_bus_addr(busAddr), .o_bus_data(busData), .o_bus_oe(busOe),
        .o_busy(busy), .o_next_state(nextState), .o_error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command and records what the DUT did; cycle 0 is the start cycle.
    task automatic driveOp(input logic [3:0] cmd, input logic [31:0] s0, s1, b, bd,
                           input int h, r, dropAt, input logic [7:0] replyCode,
                           input bit junk, input logic [7:0] junkCode, input bit early, reStart,
                           output int oDone, output logic oErr, output int oSends,
                           output logic [31:0] oAddr, oData, output logic [7:0] oMsg,
                           output int oBad);
        int sendCycle;
        logic [7:0] j;
        oDone = -1; oErr = 1'b0; oSends = 0; oAddr = '0; oData = '0; oMsg = '0; oBad = 0;
        sendCycle = h + 1;
        for (int c = 0; c < 300 && oDone < 0; c++) begin
            @(posedge clk); #1;
            start        = (c == 0) || (reStart && c == 2);
            cmdCode      = (c == 0) ? cmd : CMD_STOP;
            src0         = (c == 0) ? s0 : ~s0;
            src1         = (c == 0) ? s1 : ~s1;
            baseAddr     = b;
            baseAddrData = bd;
            dispOnline   = (c >= h);
            if (dropAt >= 0 && c >= sendCycle + 1 + dropAt) dispOnline = 1'b0;
            msgIn = '0;
            if (early && c == sendCycle) msgIn = replyCode;
            if (junk && r >= 0 && c > sendCycle && c < sendCycle + 1 + r) begin
                j = (junkCode != 8'h00) ? junkCode : 8'($urandom);
                if (j == replyCode) j = 8'h00;
                msgIn = j;
            end
            if (r >= 0 && c == sendCycle + 1 + r) msgIn = replyCode;
            @(negedge clk);
            if (c > 0) begin
                if (!busy) oBad++;
                if (msgOe) begin
                    if (oSends == 0) begin
                        oMsg  = msgOut;
                        oAddr = busAddr;
                        oData = busData;
                    end
                    oSends++;
                    if (!busOe) oBad++;
                end else if (msgOut != 8'h00) begin
                    oBad++;
                end
                if (error && !nextState) oBad++;
                if (nextState) begin
                    oDone = c;
                    oErr  = error;
                end
            end
        end
        @(posedge clk); #1;
        start = 1'b0; msgIn = '0; dispOnline = 1'b1; cmdCode = '0;
        @(negedge clk);
        if (busy) oBad++;
    endtask

    // Expected completion cycle, error flag and message count from the protocol rules.
    function automatic void modelTiming(input bit supported, input int h, r, dropAt,
                                        output int done, output bit err, output int sends);
        int s;
        if (!supported) begin
            done = 2; err = 1'b0; sends = 0;
        end else if (h > TIMEOUT) begin
            done = TIMEOUT + 1; err = 1'b1; sends = 0;
        end else begin
            s = h + 1;
            if (dropAt >= 0 && (r < 0 || dropAt < r)) begin
                done = s + 2 + dropAt; err = 1'b1; sends = 1;
            end else if (r >= 0) begin
                done = s + 2 + r; err = 1'b0; sends = 1;
            end else begin
                done = s + (RETRIES + 1) * (TIMEOUT + 1); err = 1'b1; sends = RETRIES + 1;
            end
        end
    endfunction

    task automatic applyReset();
        rstN = 1'b0; start = 1'b0; cmdCode = '0; src0 = '0; src1 = '0;
        baseAddr = '0; baseAddrData = '0; dispOnline = 1'b1; msgIn = '0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; cmdCode = '0; src0 = '0; src1 = '0;
        baseAddr = '0; baseAddrData = '0; dispOnline = 1'b1; msgIn = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({msgOut, msgOe, busOe, busy, nextState, error} !== 13'd0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %0h expected 0", {msgOut, msgOe, busOe, busy, nextState, error});
        end
        tests++;
        if ({busAddr, busData} !== 64'd0) begin
            fails++;
            $display("[TB] FAIL reset_bus: got %0h expected 0", {busAddr, busData});
        end
        @(posedge clk); #1 rstN = 1'b1;
    endtask

    task automatic test_fork();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        driveOp(CMD_FORK, 32'h100, 32'h20, 32'h1000, 32'h8000, 0, 0, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 3)           begin fails++; $display("[TB] FAIL fork_done_cycle: got %0d expected 3", d); end
        tests++; if (e !== 1'b0)        begin fails++; $display("[TB] FAIL fork_error: got %0b expected 0", e); end
        tests++; if (s !== 1)           begin fails++; $display("[TB] FAIL fork_sends: got %0d expected 1", s); end
        tests++; if (a !== 32'h1100)    begin fails++; $display("[TB] FAIL fork_addr: got %0h expected 1100", a); end
        tests++; if (dd !== 32'h8020)   begin fails++; $display("[TB] FAIL fork_data: got %0h expected 8020", dd); end
        tests++; if (m !== FORK_THRD)   begin fails++; $display("[TB] FAIL fork_msg: got %0h expected %0h", m, FORK_THRD); end
        tests++; if (bad !== 0)         begin fails++; $display("[TB] FAIL fork_protocol: got %0d expected 0", bad); end
    endtask

    task automatic test_stop();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        driveOp(CMD_STOP, 32'h40, 32'h0, 32'h1000, 32'h8000, 0, 3, -1, STOP_DONE,
                1'b1, FORK_DONE, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 6)           begin fails++; $display("[TB] FAIL stop_done_cycle: got %0d expected 6", d); end
        tests++; if (a !== 32'h1030)    begin fails++; $display("[TB] FAIL stop_addr: got %0h expected 1030", a); end
        tests++; if (dd !== 32'h0)      begin fails++; $display("[TB] FAIL stop_data: got %0h expected 0", dd); end
        tests++; if (m !== STOP_THRD)   begin fails++; $display("[TB] FAIL stop_msg: got %0h expected %0h", m, STOP_THRD); end
        tests++; if (e !== 1'b0)        begin fails++; $display("[TB] FAIL stop_error: got %0b expected 0", e); end
    endtask

    task automatic test_hold();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        driveOp(CMD_FORK, 32'h8, 32'h4, 32'h200, 32'h300, 10, 2, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 15)          begin fails++; $display("[TB] FAIL hold_done_cycle: got %0d expected 15", d); end
        tests++; if (e !== 1'b0)        begin fails++; $display("[TB] FAIL hold_error: got %0b expected 0", e); end
        tests++; if (bad !== 0)         begin fails++; $display("[TB] FAIL hold_protocol: got %0d expected 0", bad); end
    endtask

    task automatic test_timeout();
        int d, s, bad, expD; logic e; logic [31:0] a, dd; logic [7:0] m;
        expD = 1 + (RETRIES + 1) * (TIMEOUT + 1);
        driveOp(CMD_FORK, 32'h1, 32'h2, 32'h3, 32'h4, 0, -1, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== expD)        begin fails++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", d, expD); end
        tests++; if (e !== 1'b1)        begin fails++; $display("[TB] FAIL timeout_error: got %0b expected 1", e); end
        tests++; if (s !== RETRIES + 1) begin fails++; $display("[TB] FAIL timeout_sends: got %0d expected %0d", s, RETRIES + 1); end
        driveOp(CMD_STOP, 32'h50, 32'h60, 32'h100, 32'h100, 0, -1, 2, STOP_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 5 || e !== 1'b1) begin fails++; $display("[TB] FAIL offline_abort: got %0d/%0b expected 5/1", d, e); end
    endtask

    task automatic test_wrap_unsupported();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        driveOp(CMD_FORK, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h10, 32'h2, 0, 1, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (a !== 32'h8)       begin fails++; $display("[TB] FAIL wrap_addr: got %0h expected 8", a); end
        tests++; if (dd !== 32'h1)      begin fails++; $display("[TB] FAIL wrap_data: got %0h expected 1", dd); end
        driveOp(4'hB, 32'h1, 32'h1, 32'h1, 32'h1, 0, -1, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 2)           begin fails++; $display("[TB] FAIL unsupported_cycle: got %0d expected 2", d); end
        tests++; if (s !== 0 || bad !== 0) begin fails++; $display("[TB] FAIL unsupported_msg: got %0d/%0d expected 0/0", s, bad); end
    endtask

    task automatic test_early_reply();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        driveOp(CMD_FORK, 32'h10, 32'h0, 32'h20, 32'h30, 0, 4, -1, FORK_DONE,
                1'b0, 8'h00, 1'b1, 1'b1, d, e, s, a, dd, m, bad);
        tests++; if (d !== 7)           begin fails++; $display("[TB] FAIL early_reply_cycle: got %0d expected 7", d); end
        tests++; if (a !== 32'h30 || s !== 1) begin fails++; $display("[TB] FAIL busy_restart: got %0h/%0d expected 30/1", a, s); end
    endtask

    task automatic test_reset_mid();
        int d, s, bad; logic e; logic [31:0] a, dd; logic [7:0] m;
        @(posedge clk); #1;
        start = 1'b1; cmdCode = CMD_FORK; src0 = 32'h5; src1 = 32'h6;
        baseAddr = 32'h100; baseAddrData = 32'h200; dispOnline = 1'b1; msgIn = '0;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({busy, busOe} !== 2'b11) begin fails++; $display("[TB] FAIL mid_wait_state: got %0b expected 11", {busy, busOe}); end
        rstN = 1'b0; #1;
        tests++;
        if ({msgOut, msgOe, busOe, busy, nextState, error, busAddr, busData} !== '0) begin
            fails++;
            $display("[TB] FAIL mid_reset_outputs: got %0h expected 0", {msgOut, msgOe, busOe, busy, nextState, error, busAddr, busData});
        end
        @(posedge clk); #1 rstN = 1'b1;
        driveOp(CMD_FORK, 32'h5, 32'h6, 32'h100, 32'h200, 0, 0, -1, FORK_DONE,
                1'b0, 8'h00, 1'b0, 1'b0, d, e, s, a, dd, m, bad);
        tests++; if (d !== 3 || s !== 1 || e !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_op: got %0d/%0d/%0b expected 3/1/0", d, s, e); end
    endtask

    task automatic test_random();
        int d, s, bad, h, r, dropAt, sel, expD, expS;
        bit expE, sup, isStop;
        logic e; logic [31:0] a, dd, s0, s1, b, bd, expA, expDd, hdr; logic [7:0] m, rc;
        logic [3:0] cmd;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 5);
            if (sel <= 2) cmd = CMD_FORK;
            else if (sel <= 4) cmd = CMD_STOP;
            else begin
                cmd = 4'($urandom_range(6, 15));
            end
            sup    = (sel <= 4);
            isStop = (cmd == CMD_STOP);
            s0 = $urandom; s1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            b  = $urandom; bd = $urandom;
            h  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 14);
            r  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TIMEOUT - 1) : -1;
            dropAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : -1;
            rc = isStop ? STOP_DONE : FORK_DONE;
            driveOp(cmd, s0, s1, b, bd, h, r, dropAt, rc, 1'($urandom), 8'h00,
                    1'($urandom), 1'($urandom), d, e, s, a, dd, m, bad);
            modelTiming(sup, h, r, dropAt, expD, expE, expS);
            hdr   = isStop ? 32'(HDR_SPACE) : 32'h0;
            expA  = s0 + b - hdr;
            expDd = (s1 == 32'h0) ? 32'h0 : s1 + bd - hdr;
            tests++; if (d !== expD) begin fails++; $display("[TB] FAIL rand%0d_cycle: got %0d expected %0d", n, d, expD); end
            tests++; if (e !== expE) begin fails++; $display("[TB] FAIL rand%0d_error: got %0b expected %0b", n, e, expE); end
            tests++; if (s !== expS) begin fails++; $display("[TB] FAIL rand%0d_sends: got %0d expected %0d", n, s, expS); end
            tests++; if (bad !== 0)  begin fails++; $display("[TB] FAIL rand%0d_protocol: got %0d expected 0", n, bad); end
            if (expS > 0) begin
                tests++;
                if (a !== expA || dd !== expDd || m !== (isStop ? STOP_THRD : FORK_THRD)) begin
                    fails++;
                    $display("[TB] FAIL rand%0d_payload: got %0h/%0h/%0h expected %0h/%0h/%0h", n, a, dd, m,
                             expA, expDd, isStop ? STOP_THRD : FORK_THRD);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        applyReset();
        test_fork();
        test_stop();
        test_hold();
        test_timeout();
        test_wrap_unsupported();
        test_early_reply();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thread_msg_engine.md
Name: thread_msg_engine

Overview:
Parametrised thread-control request engine for the ALU stage. It turns CMD_FORK and CMD_STOP into inter-CPU dispatcher messages (CPU_R_FORK_THRD / CPU_R_STOP_THRD) and drives the thread address and data onto the shared bus. It waits for the matching *_DONE reply, with a timeout, then signals next_state. Successor to the single-shot tristate thread controller: explicit FSM, drive enables instead of internal tristates, timeout/error reporting, width parameters.

Parameters:
ADDR_W, 32, width of addr/base_addr
DATA_W, 32, width of data/src/base_addr_data
MSG_W, 8, inter-CPU message width
HDR_SPACE, 16, thread header size subtracted for STOP (THREAD_HEADER_SPACE value)
TIMEOUT, 255, max cycles in WAIT before error (1..2^16-1)
MAX_RETRY, 2, resend count, used only with THREAD_MSG_RETRY_EN

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, valid when ALU_BEGIN issues a thread command
cmd_code  in  4  command[31:28]
src0  in  DATA_W  thread entry offset
src1  in  DATA_W  thread data offset, 0 = none
base_addr  in  ADDR_W  code base
base_addr_data  in  ADDR_W  data base
disp_online  in  1  dispatcher present
msg_in  in  MSG_W  message from dispatcher
msg_out  out  MSG_W  message to dispatcher, 0 = idle
msg_oe  out  1  msg_out drives shared msg bus
bus_addr  out  ADDR_W  thread address
bus_data  out  DATA_W  thread data pointer
bus_oe  out  1  bus_addr/bus_data drive shared bus
busy  out  1  FSM not IDLE
next_state  out  1  one-cycle pulse: command complete
error  out  1  one-cycle pulse with next_state on timeout/offline abort

Behaviour:
- Reset (rst=0, async): state IDLE; msg_out=0, msg_oe=0, bus_oe=0, bus_addr=0, bus_data=0, busy=0, next_state=0, error=0, timer=0, retry=0.
- States: IDLE, HOLD, SEND, WAIT, DONE.
- IDLE: start=1 with cmd_code=CMD_FORK or CMD_STOP -> latch operands and compute:
  FORK: addr=src0+base_addr; data=(src1==0)?0:src1+base_addr_data.
  STOP: addr=src0+base_addr-HDR_SPACE; data=(src1==0)?0:src1+base_addr_data-HDR_SPACE.
  Arithmetic is modulo 2^ADDR_W, operands truncated or zero-extended to ADDR_W. A zero-valued data field is never offset.
  Next state: HOLD if disp_online=0, else SEND. start with any other cmd_code -> DONE, next_state pulses 1 cycle later, no message. start while busy is ignored.
- HOLD: wait for disp_online=1 -> SEND. Timer counts here too; expiry -> DONE with error.
- SEND (exactly 1 cycle): msg_out=FORK_THRD/STOP_THRD, msg_oe=1, bus_oe=1, timer cleared -> WAIT.
- WAIT: msg_out=0, msg_oe=0 (bus released for reply), bus_oe stays 1.
  - msg_in==matching *_DONE -> DONE.
  - Non-matching replies are ignored.
  - disp_online dropping -> DONE with error.
  - timer reaching TIMEOUT -> DONE with error.
- DONE (1 cycle): next_state=1, error as recorded, bus_oe=0 -> IDLE. Earliest completion: start at T, SEND at T+1, reply seen at T+2, next_state at T+3.
- A reply arriving during SEND is not accepted.
- Reset mid-operation: immediate return to reset values; no message is resent.

Optional Feature:
THREAD_MSG_RETRY_EN:
- Defined: WAIT timeout with retry<MAX_RETRY -> increment retry, go to SEND (message reissued, timer cleared). error only after MAX_RETRY resends also time out.
- Undefined: first timeout ends in error, and MAX_RETRY is unused.

Test Plan:
- FORK, src0=0x100, src1=0x20, base_addr=0x1000, base_addr_data=0x8000, online; reply FORK_DONE 1 cycle after SEND -> bus_addr=0x1100, bus_data=0x8020, msg_out=FORK_THRD for 1 cycle, next_state at T+3, error=0.
- STOP, src0=0x40, src1=0, base_addr=0x1000 -> bus_addr=0x1030 (HDR_SPACE=16), bus_data=0, completes on STOP_DONE only; an earlier FORK_DONE is ignored.
- FORK with disp_online=0 for 10 cycles, then 1 -> HOLD for 10 cycles, then SEND; normal completion.
- No reply, TIMEOUT=8 -> next_state and error pulse together 8 cycles after WAIT entry. With THREAD_MSG_RETRY_EN and MAX_RETRY=2: 3 SEND pulses, then error.
- Wrap: src0=0xFFFFFFF8, base_addr=0x10 -> bus_addr=0x8; unsupported cmd_code -> next_state 2 cycles after start, msg_out stays 0.
- rst asserted low during WAIT -> all outputs 0 in the same cycle; the next start behaves as fresh.
